// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock display path: digit slot
// numbering and the active-high 7-segment font (gfedcba).
package clock_pkg;

    localparam int NUM_DIGITS = 6;

    localparam int DIG_SL = 0;
    localparam int DIG_SH = 1;
    localparam int DIG_ML = 2;
    localparam int DIG_MH = 3;
    localparam int DIG_HL = 4;
    localparam int DIG_HH = 5;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg7_t;

    // Codes 10..15 are not BCD and render as a dark digit.
    localparam seg7_t SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to active-high 7-segment decoder, shared with the alarm/display blocks.
module bcd_to_seg7
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure table lookup; invalid codes map to all-off in the table.
    assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/seg_scan6.sv
// Six-digit multiplexed 7-segment driver: per-frame tear-free snapshot of
// the time digits, per-digit blink, hour leading-zero blanking and a
// blinking colon on the decimal points of slots 1 and 3.
module seg_scan6
    import clock_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hh,
    input  logic [3:0] hl,
    input  logic [3:0] mh,
    input  logic [3:0] ml,
    input  logic [3:0] sh,
    input  logic [3:0] sl,
    input  logic [5:0] blink_mask,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int   CW      = $clog2(SCAN_DIV);
    localparam int   FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [FW-1:0] fcnt;
    logic          phase;
    bcd_t          snap [NUM_DIGITS];

    logic          scan_end;
    logic          frame_end;
    bcd_t          digit;
    logic          blink_sel;
    logic          blank;
    logic [6:0]    seg_raw;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [5:0]    an_nxt;

    assign scan_end  = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = scan_end && (idx == 3'(DIG_HH));

    // Slot prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (scan_end) begin
            cnt <= '0;
            idx <= (idx == 3'(DIG_HH)) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Blink frame counter and phase; phase 1 is the dark half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (frame_end) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Snapshot the time digits once per frame so a frame never mixes two times.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
        end else if (frame_end) begin
            snap[DIG_SL] <= sl;
            snap[DIG_SH] <= sh;
            snap[DIG_ML] <= ml;
            snap[DIG_MH] <= mh;
            snap[DIG_HL] <= hl;
            snap[DIG_HH] <= hh;
        end
    end

    // Select the current slot's digit and blink bit; build the one-hot enable.
    // Enables stay off for the first clock of each slot to avoid ghosting.
    always_comb begin
        digit     = '0;
        blink_sel = 1'b0;
        an_nxt    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                digit     = snap[i];
                blink_sel = blink_mask[i];
                an_nxt[i] = (cnt != '0);
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (seg_raw)
    );

    // Blanking and colon decisions, active-high before polarity.
    always_comb begin
        blank   = (blink_sel && phase) ||
                  ((idx == 3'(DIG_HH)) && blank_lz && (digit == 4'd0));
        seg_nxt = blank ? 7'h00 : seg_raw;
        dp_nxt  = ((idx == 3'(DIG_SH)) || (idx == 3'(DIG_MH))) && !phase;
    end

    // Registered, polarity-adjusted outputs; reset drives everything dark.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg        <= {7{SEG_INV}};
            dp         <= SEG_INV;
            an         <= {6{DIG_INV}};
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt ^ {7{SEG_INV}};
            dp         <= dp_nxt ^ SEG_INV;
            an         <= an_nxt ^ {6{DIG_INV}};
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan6.sv
// Directed bench for seg_scan6 with SCAN_DIV=4, BLINK_FRAMES=2, active-low
// segments and digits. Cycle k (k-th edge after reset release) shows the
// slot with cnt=(k-1)%4, idx=((k-1)/4)%6 of frame (k-1)/24.
module tb_seg_scan6;

    logic       clk;
    logic       rst;
    logic [3:0] hh, hl, mh, ml, sh, sl;
    logic [5:0] blink_mask;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    seg_scan6 #(
        .SCAN_DIV       (4),
        .BLINK_FRAMES   (2),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hh         (hh),
        .hl         (hl),
        .mh         (mh),
        .ml         (ml),
        .sh         (sh),
        .sl         (sl),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic [23:0] tim;     // {hh,hl,mh,ml,sh,sl} as hex nibbles
        logic [5:0]  blink;
        logic        blz;
        logic [6:0]  seg;
        logic [5:0]  an;
        logic        dp;
        logic        ft;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int c, logic [23:0] t, logic [5:0] b, logic z,
                                logic [6:0] s, logic [5:0] a, logic d, logic f,
                                string n);
        vec_t v;
        v.cyc = c; v.tim = t; v.blink = b; v.blz = z;
        v.seg = s; v.an = a; v.dp = d; v.ft = f; v.name = n;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_all(input string nm, input logic [6:0] s, input logic [5:0] a,
                           input logic d, input logic f);
        chk({nm, ".seg"}, {1'b0, seg}, {1'b0, s});
        chk({nm, ".an"},  {2'b0, an},  {2'b0, a});
        chk({nm, ".dp"},  {7'b0, dp},  {7'b0, d});
        chk({nm, ".ft"},  {7'b0, frame_tick}, {7'b0, f});
    endtask

    task automatic step_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL step_to: at cyc %0d expected cyc %0d", cyc, target);
        end
    endtask

    initial begin
        // D: 23:59:58   M: 23:50:58   H0: 03:50:58   HC: 0C:50:58
        vecs.push_back(mk(  1, 24'h235958, 6'h00, 0, 7'h40, 6'h3F, 1, 0, "f0_ghost"));
        vecs.push_back(mk(  2, 24'h235958, 6'h00, 0, 7'h40, 6'h3E, 1, 0, "f0_s0"));
        vecs.push_back(mk(  6, 24'h235958, 6'h00, 0, 7'h40, 6'h3D, 0, 0, "f0_s1_dp"));
        vecs.push_back(mk( 22, 24'h235958, 6'h00, 0, 7'h40, 6'h1F, 1, 0, "f0_s5"));
        vecs.push_back(mk( 24, 24'h235958, 6'h00, 0, 7'h40, 6'h1F, 1, 1, "ft_first"));
        vecs.push_back(mk( 25, 24'h235958, 6'h00, 0, 7'h00, 6'h3F, 1, 0, "f1_ghost"));
        vecs.push_back(mk( 26, 24'h235958, 6'h00, 0, 7'h00, 6'h3E, 1, 0, "f1_sl8"));
        vecs.push_back(mk( 30, 24'h235958, 6'h00, 0, 7'h12, 6'h3D, 0, 0, "f1_sh5"));
        vecs.push_back(mk( 34, 24'h235058, 6'h00, 0, 7'h10, 6'h3B, 1, 0, "ml_hold"));
        vecs.push_back(mk( 38, 24'h235058, 6'h00, 0, 7'h12, 6'h37, 0, 0, "f1_mh5"));
        vecs.push_back(mk( 42, 24'h235058, 6'h00, 0, 7'h30, 6'h2F, 1, 0, "f1_hl3"));
        vecs.push_back(mk( 46, 24'h235058, 6'h00, 0, 7'h24, 6'h1F, 1, 0, "f1_hh2"));
        vecs.push_back(mk( 48, 24'h235058, 6'h00, 0, 7'h24, 6'h1F, 1, 1, "ft_second"));
        vecs.push_back(mk( 54, 24'h235058, 6'h00, 0, 7'h12, 6'h3D, 1, 0, "dp_ph1"));
        vecs.push_back(mk( 58, 24'h035058, 6'h00, 1, 7'h40, 6'h3B, 1, 0, "ml_new"));
        vecs.push_back(mk( 70, 24'h035058, 6'h00, 1, 7'h24, 6'h1F, 1, 0, "hh_old"));
        vecs.push_back(mk( 94, 24'h0C5058, 6'h00, 1, 7'h7F, 6'h1F, 1, 0, "lz_blank"));
        vecs.push_back(mk( 95, 24'h0C5058, 6'h00, 0, 7'h40, 6'h1F, 1, 0, "lz_off"));
        vecs.push_back(mk(113, 24'h0C5058, 6'h00, 0, 7'h7F, 6'h3F, 1, 0, "ghost_inv"));
        vecs.push_back(mk(114, 24'h0C5058, 6'h00, 0, 7'h7F, 6'h2F, 1, 0, "invalid_c"));
        vecs.push_back(mk(118, 24'h235058, 6'h30, 0, 7'h40, 6'h1F, 1, 0, "blink_f4"));
        vecs.push_back(mk(126, 24'h235058, 6'h30, 0, 7'h12, 6'h3D, 0, 0, "blink_f5_s1"));
        vecs.push_back(mk(138, 24'h235058, 6'h30, 0, 7'h30, 6'h2F, 1, 0, "blink_f5_s4"));
        vecs.push_back(mk(142, 24'h235058, 6'h30, 0, 7'h24, 6'h1F, 1, 0, "blink_f5_s5"));
        vecs.push_back(mk(144, 24'h235058, 6'h30, 0, 7'h24, 6'h1F, 1, 1, "blink_ft"));
        vecs.push_back(mk(146, 24'h235058, 6'h30, 0, 7'h00, 6'h3E, 1, 0, "blink_f6_s0"));
        vecs.push_back(mk(150, 24'h235058, 6'h30, 0, 7'h12, 6'h3D, 1, 0, "blink_f6_s1"));
        vecs.push_back(mk(162, 24'h235058, 6'h30, 0, 7'h7F, 6'h2F, 1, 0, "blink_f6_s4"));
        vecs.push_back(mk(166, 24'h235058, 6'h30, 0, 7'h7F, 6'h1F, 1, 0, "blink_f6_s5"));
        vecs.push_back(mk(190, 24'h235058, 6'h30, 0, 7'h7F, 6'h1F, 1, 0, "blink_f7_s5"));
        vecs.push_back(mk(198, 24'h235058, 6'h30, 0, 7'h12, 6'h3D, 0, 0, "blink_f8_s1"));
        vecs.push_back(mk(214, 24'h235058, 6'h30, 0, 7'h24, 6'h1F, 1, 0, "blink_f8_s5"));

        rst = 1'b0;
        {hh, hl, mh, ml, sh, sl} = 24'h235958;
        blink_mask = 6'h00;
        blank_lz   = 1'b0;

        #12;
        chk_all("reset", 7'h7F, 6'h3F, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            {hh, hl, mh, ml, sh, sl} = vecs[i].tim;
            blink_mask = vecs[i].blink;
            blank_lz   = vecs[i].blz;
            step_to(vecs[i].cyc);
            chk_all(vecs[i].name, vecs[i].seg, vecs[i].an, vecs[i].dp, vecs[i].ft);
        end

        // Reset in the middle of slot 3 of frame 9: outputs go dark at once.
        step_to(230);
        rst = 1'b0;
        #1;
        chk_all("mid_reset", 7'h7F, 6'h3F, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Scan restarts at slot 0 with a zero snapshot; next tick 24 clocks on.
        step_to(1);
        chk("rst_restart_ghost.an", {2'b0, an}, 8'h3F);
        chk("rst_restart.seg", {1'b0, seg}, 8'h40);
        step_to(2);
        chk("rst_restart_s0.an", {2'b0, an}, 8'h3E);
        for (int k = 3; k <= 25; k++) begin
            step_to(k);
            chk($sformatf("rst_ft_%0d", k), {7'b0, frame_tick}, (k == 24) ? 8'h01 : 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
